audio_stream_ctrl: RTL and testbench

Controller that sequences the SPI audio receiver and turns its bursty 16-bit sample output into a steady sample-rate stream. It drives the receiver's `active` enable, buffers received words in a small FIFO, and releases one sample per sample-rate tick to the downstream audio path. It also runs a link watchdog that resynchronises the receiver when frames stop arriving, and keeps sticky overrun/underrun status.

---
 rtl/audio_stream_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_audio_stream_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_ctrl.sv
// Sequences the SPI audio receiver and re-times its bursty 16-bit words into a
// steady one-sample-per-tick stream, with a link watchdog and sticky status.
module audio_stream_ctrl #(
  parameter int clock_max      = 25_000_000,
  parameter int sample_rate    = 48_000,
  parameter int fifo_depth     = 8,
  parameter int timeout_cycles = 25_000,
  parameter int resync_cycles  = 16
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear_flags,
  input  logic [15:0]               rx_sample,
  input  logic                      rx_valid,
  output logic                      rx_active,
  output logic [15:0]               sample_out,
  output logic                      sample_strobe,
  output logic [$clog2(fifo_depth):0] fifo_level,
  output logic                      overrun,
  output logic                      underrun,
  output logic [7:0]                resync_count,
  output logic [1:0]                state_out
);

  localparam int period = clock_max / sample_rate;
  localparam int div_w  = (period > 1) ? $clog2(period) : 1;
  localparam int ptr_w  = $clog2(fifo_depth);
  localparam int lvl_w  = ptr_w + 1;
  localparam int wd_w   = $clog2(timeout_cycles + 1);
  localparam int rs_w   = (resync_cycles > 1) ? $clog2(resync_cycles) : 1;

  localparam logic [div_w-1:0] div_last  = div_w'(period - 1);
  localparam logic [wd_w-1:0]  wd_last   = wd_w'(timeout_cycles - 1);
  localparam logic [rs_w-1:0]  rs_last   = rs_w'(resync_cycles - 1);
  localparam logic [lvl_w-1:0] lvl_full  = lvl_w'(fifo_depth);
  localparam logic [lvl_w-1:0] lvl_prime = lvl_w'(fifo_depth / 2);

  typedef enum logic [1:0] {
    st_off    = 2'd0,
    st_prime  = 2'd1,
    st_run    = 2'd2,
    st_resync = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [div_w-1:0] div_cnt;
  logic [wd_w-1:0]  wd_cnt;
  logic [rs_w-1:0]  rs_cnt;

  logic [15:0]      mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;

  logic wd_hit;
  logic push_req;
  logic push;
  logic pop;
  logic tick;
  logic fifo_empty;
  logic fifo_full;
  logic overrun_set;
  logic underrun_set;
  logic flush;
  logic resync_enter;
  logic rx_active_d;

  // rx_valid is a one-cycle strobe qualifying rx_sample. The receiver has no
  // ready/backpressure input, so a word that meets a full FIFO is dropped and
  // flagged rather than stalled.
  assign wd_hit = !rx_valid && (wd_cnt == wd_last);

  // State register
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state <= st_off;
    else        state <= next_state;
  end

  // Next-state logic; a low enable overrides every other transition
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = st_off;
    end else begin
      case (state)
        st_off:    next_state = st_prime;
        st_prime: begin
          if (wd_hit)                      next_state = st_resync;
          else if (fifo_level >= lvl_prime) next_state = st_run;
        end
        st_run: begin
          if (wd_hit) next_state = st_resync;
        end
        st_resync: begin
          if (rs_cnt == rs_last) next_state = st_prime;
        end
        default:   next_state = st_off;
      endcase
    end
  end

  // Output / datapath control decode
  always_comb begin
    fifo_empty   = (fifo_level == '0);
    fifo_full    = (fifo_level == lvl_full);
    push_req     = rx_valid && enable && (state == st_prime || state == st_run);
    tick         = (state == st_run) && (next_state == st_run) && (div_cnt == div_last);
    pop          = tick && !fifo_empty;
    push         = push_req && (!fifo_full || pop);
    overrun_set  = push_req && fifo_full && !pop;
    underrun_set = tick && fifo_empty;
    resync_enter = (next_state == st_resync) && (state != st_resync);
    flush        = (next_state == st_off) || resync_enter;
    rx_active_d  = (next_state == st_prime) || (next_state == st_run);
  end

  // Sample-rate divider, watchdog and resync hold counters
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      wd_cnt  <= '0;
      rs_cnt  <= '0;
    end else begin
      if (state == st_run && next_state == st_run)
        div_cnt <= tick ? '0 : div_cnt + div_w'(1);
      else
        div_cnt <= '0;

      if ((state == st_prime || state == st_run) &&
          (next_state == st_prime || next_state == st_run))
        wd_cnt <= rx_valid ? '0 : wd_cnt + wd_w'(1);
      else
        wd_cnt <= '0;

      if (state == st_resync && next_state == st_resync)
        rs_cnt <= rs_cnt + rs_w'(1);
      else
        rs_cnt <= '0;
    end
  end

  // Storage has no reset; occupancy is tracked by the pointers and level
  always_ff @(posedge clk_in) begin
    if (push && !flush) mem[wr_ptr] <= rx_sample;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + lvl_w'(1);
        2'b01:   fifo_level <= fifo_level - lvl_w'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Output sample, strobe and receiver enable
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sample_out    <= '0;
      sample_strobe <= 1'b0;
      rx_active     <= 1'b0;
    end else begin
      sample_strobe <= tick;
      rx_active     <= rx_active_d;
      if (flush)    sample_out <= '0;
      else if (pop) sample_out <= mem[rd_ptr];
    end
  end

  // Sticky status; a set event in the same cycle as clear_flags wins
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      overrun      <= 1'b0;
      underrun     <= 1'b0;
      resync_count <= '0;
    end else begin
      if (overrun_set)      overrun <= 1'b1;
      else if (clear_flags) overrun <= 1'b0;

      if (underrun_set)     underrun <= 1'b1;
      else if (clear_flags) underrun <= 1'b0;

      if (resync_enter)
        resync_count <= (resync_count != 8'hff) ? resync_count + 8'd1 : resync_count;
      else if (clear_flags)
        resync_count <= '0;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl with P=10, depth 8, timeout 50, resync 4.
module tb_audio_stream_ctrl;

  logic        clk_in;
  logic        reset;
  logic        enable;
  logic        clear_flags;
  logic [15:0] rx_sample;
  logic        rx_valid;
  logic        rx_active;
  logic [15:0] sample_out;
  logic        sample_strobe;
  logic [3:0]  fifo_level;
  logic        overrun;
  logic        underrun;
  logic [7:0]  resync_count;
  logic [1:0]  state_out;

  int checks;
  int errors;
  logic [15:0] exp_q[$];
  logic [15:0] exp;

  audio_stream_ctrl #(
    .clock_max(1000),
    .sample_rate(100),
    .fifo_depth(8),
    .timeout_cycles(50),
    .resync_cycles(4)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .enable(enable),
    .clear_flags(clear_flags),
    .rx_sample(rx_sample),
    .rx_valid(rx_valid),
    .rx_active(rx_active),
    .sample_out(sample_out),
    .sample_strobe(sample_strobe),
    .fifo_level(fifo_level),
    .overrun(overrun),
    .underrun(underrun),
    .resync_count(resync_count),
    .state_out(state_out)
  );

  // Clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // One clock: inputs set after this return are sampled at the next edge
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    rx_valid  = 1'b1;
    rx_sample = w;
    cyc();
    rx_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; clear_flags = 1'b0; rx_valid = 1'b0; rx_sample = '0;
    repeat (3) cyc();
    checks++; if (state_out !== 2'd0)     begin errors++; $display("FAIL reset_state got %0d exp 0", state_out); end
    checks++; if (rx_active !== 1'b0)     begin errors++; $display("FAIL reset_rx_active got %b exp 0", rx_active); end
    checks++; if (sample_out !== 16'h0)   begin errors++; $display("FAIL reset_sample got %h exp 0000", sample_out); end
    checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", sample_strobe); end
    checks++; if (fifo_level !== 4'd0)    begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if ({overrun, underrun} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overrun, underrun}); end
    checks++; if (resync_count !== 8'd0)  begin errors++; $display("FAIL reset_resync got %0d exp 0", resync_count); end
    reset = 1'b1;
    cyc();
    checks++; if (state_out !== 2'd0)     begin errors++; $display("FAIL off_idle_state got %0d exp 0", state_out); end
  endtask

  task automatic test_prime_run();
    enable = 1'b1;
    cyc();
    checks++; if (state_out !== 2'd1)  begin errors++; $display("FAIL prime_state got %0d exp 1", state_out); end
    checks++; if (rx_active !== 1'b1)  begin errors++; $display("FAIL prime_rx_active got %b exp 1", rx_active); end
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(16'(i));
      push_word(16'(i));
    end
    checks++; if (fifo_level !== 4'd4) begin errors++; $display("FAIL prime_level got %0d exp 4", fifo_level); end
    checks++; if (state_out !== 2'd1)  begin errors++; $display("FAIL prime_hold got %0d exp 1", state_out); end
    cyc();
    checks++; if (state_out !== 2'd2)  begin errors++; $display("FAIL run_state got %0d exp 2", state_out); end
    for (int k = 0; k < 4; k++) begin
      repeat (9) cyc();
      checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL strobe_gap%0d got %b exp 0", k, sample_strobe); end
      cyc();
      exp = exp_q.pop_front();
      checks++; if (sample_strobe !== 1'b1) begin errors++; $display("FAIL strobe%0d got %b exp 1", k, sample_strobe); end
      checks++; if (sample_out !== exp)     begin errors++; $display("FAIL sample%0d got %h exp %h", k, sample_out, exp); end
      checks++; if (fifo_level !== 4'(3 - k)) begin errors++; $display("FAIL drain_level%0d got %0d exp %0d", k, fifo_level, 3 - k); end
    end
    // One more word keeps the watchdog alive while the FIFO runs dry
    push_word(16'h0005);
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL w5_level got %0d exp 1", fifo_level); end
    repeat (8) cyc();
    cyc();
    checks++; if (sample_strobe !== 1'b1)  begin errors++; $display("FAIL strobe4 got %b exp 1", sample_strobe); end
    checks++; if (sample_out !== 16'h0005) begin errors++; $display("FAIL sample4 got %h exp 0005", sample_out); end
    checks++; if (underrun !== 1'b0)       begin errors++; $display("FAIL no_underrun got %b exp 0", underrun); end
  endtask

  task automatic test_underrun();
    // Tick on an empty FIFO coinciding with a push
    repeat (9) cyc();
    push_word(16'h0006);
    checks++; if (sample_strobe !== 1'b1)  begin errors++; $display("FAIL ur_strobe got %b exp 1", sample_strobe); end
    checks++; if (sample_out !== 16'h0005) begin errors++; $display("FAIL ur_hold got %h exp 0005", sample_out); end
    checks++; if (underrun !== 1'b1)       begin errors++; $display("FAIL ur_flag got %b exp 1", underrun); end
    checks++; if (fifo_level !== 4'd1)     begin errors++; $display("FAIL ur_level got %0d exp 1", fifo_level); end
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    checks++; if (underrun !== 1'b0)       begin errors++; $display("FAIL ur_clear got %b exp 0", underrun); end
    repeat (8) cyc();
    cyc();
    checks++; if (sample_out !== 16'h0006) begin errors++; $display("FAIL ur_next got %h exp 0006", sample_out); end
    checks++; if (fifo_level !== 4'd0)     begin errors++; $display("FAIL ur_next_level got %0d exp 0", fifo_level); end
    checks++; if (underrun !== 1'b0)       begin errors++; $display("FAIL ur_stay_clear got %b exp 0", underrun); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) begin
      rx_valid  = 1'b1;
      rx_sample = 16'h0100 + 16'(i);
      exp_q.push_back(rx_sample);
      cyc();
    end
    rx_sample = 16'hBEEF;
    cyc();
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ov_level got %0d exp 8", fifo_level); end
    checks++; if (overrun !== 1'b1)    begin errors++; $display("FAIL ov_flag got %b exp 1", overrun); end
    // Full FIFO: push and pop on the same tick, plus a clear
    clear_flags = 1'b1;
    rx_sample   = 16'h0200;
    cyc();
    rx_valid    = 1'b0;
    clear_flags = 1'b0;
    exp_q.push_back(16'h0200);
    exp = exp_q.pop_front();
    checks++; if (sample_strobe !== 1'b1) begin errors++; $display("FAIL full_strobe got %b exp 1", sample_strobe); end
    checks++; if (sample_out !== exp)     begin errors++; $display("FAIL full_sample got %h exp %h", sample_out, exp); end
    checks++; if (fifo_level !== 4'd8)    begin errors++; $display("FAIL full_level got %0d exp 8", fifo_level); end
    checks++; if (overrun !== 1'b0)       begin errors++; $display("FAIL full_no_ov got %b exp 0", overrun); end
    for (int k = 1; k <= 4; k++) begin
      repeat (10) cyc();
      exp = exp_q.pop_front();
      checks++; if (sample_out !== exp)     begin errors++; $display("FAIL ov_sample%0d got %h exp %h", k, sample_out, exp); end
      checks++; if (fifo_level !== 4'(8 - k)) begin errors++; $display("FAIL ov_level%0d got %0d exp %0d", k, fifo_level, 8 - k); end
    end
  endtask

  task automatic test_watchdog();
    // Last valid was 40 cycles ago; RESYNC lands 10 cycles from now
    repeat (9) cyc();
    checks++; if (state_out !== 2'd2)    begin errors++; $display("FAIL wd_pre_state got %0d exp 2", state_out); end
    cyc();
    checks++; if (state_out !== 2'd3)    begin errors++; $display("FAIL wd_state got %0d exp 3", state_out); end
    checks++; if (rx_active !== 1'b0)    begin errors++; $display("FAIL wd_rx_active got %b exp 0", rx_active); end
    checks++; if (sample_out !== 16'h0)  begin errors++; $display("FAIL wd_sample got %h exp 0000", sample_out); end
    checks++; if (fifo_level !== 4'd0)   begin errors++; $display("FAIL wd_level got %0d exp 0", fifo_level); end
    checks++; if (resync_count !== 8'd1) begin errors++; $display("FAIL wd_count got %0d exp 1", resync_count); end
    checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL wd_strobe got %b exp 0", sample_strobe); end
    for (int j = 1; j <= 3; j++) begin
      cyc();
      checks++; if ({state_out, rx_active} !== 3'b110) begin errors++; $display("FAIL wd_hold%0d got %b exp 110", j, {state_out, rx_active}); end
    end
    cyc();
    checks++; if ({state_out, rx_active} !== 3'b011) begin errors++; $display("FAIL wd_exit got %b exp 011", {state_out, rx_active}); end
    exp_q.delete();
  endtask

  task automatic test_enable_drop();
    for (int i = 1; i <= 4; i++) push_word(16'h0300 + 16'(i));
    cyc();
    checks++; if (state_out !== 2'd2)      begin errors++; $display("FAIL ed_run got %0d exp 2", state_out); end
    push_word(16'h0305);
    repeat (9) cyc();
    checks++; if (sample_out !== 16'h0301) begin errors++; $display("FAIL ed_sample got %h exp 0301", sample_out); end
    push_word(16'h0306);
    checks++; if (fifo_level !== 4'd5)     begin errors++; $display("FAIL ed_level5 got %0d exp 5", fifo_level); end
    enable = 1'b0;
    cyc();
    checks++; if (state_out !== 2'd0)      begin errors++; $display("FAIL ed_state got %0d exp 0", state_out); end
    checks++; if (rx_active !== 1'b0)      begin errors++; $display("FAIL ed_rx_active got %b exp 0", rx_active); end
    checks++; if (fifo_level !== 4'd0)     begin errors++; $display("FAIL ed_level got %0d exp 0", fifo_level); end
    checks++; if (sample_out !== 16'h0)    begin errors++; $display("FAIL ed_flush got %h exp 0000", sample_out); end
    push_word(16'h0307);
    checks++; if (fifo_level !== 4'd0)     begin errors++; $display("FAIL off_ignore got %0d exp 0", fifo_level); end
  endtask

  task automatic test_reset_mid_run();
    enable = 1'b1;
    cyc();
    for (int i = 1; i <= 4; i++) push_word(16'h0400 + 16'(i));
    cyc();
    repeat (10) cyc();
    checks++; if ({sample_strobe, sample_out} !== {1'b1, 16'h0401}) begin errors++; $display("FAIL rm_pre got %b/%h exp 1/0401", sample_strobe, sample_out); end
    reset = 1'b0;
    #2;
    checks++; if (state_out !== 2'd0)     begin errors++; $display("FAIL rm_state got %0d exp 0", state_out); end
    checks++; if (rx_active !== 1'b0)     begin errors++; $display("FAIL rm_rx_active got %b exp 0", rx_active); end
    checks++; if (sample_out !== 16'h0)   begin errors++; $display("FAIL rm_sample got %h exp 0000", sample_out); end
    checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL rm_strobe got %b exp 0", sample_strobe); end
    checks++; if (fifo_level !== 4'd0)    begin errors++; $display("FAIL rm_level got %0d exp 0", fifo_level); end
    checks++; if (resync_count !== 8'd0)  begin errors++; $display("FAIL rm_count got %0d exp 0", resync_count); end
    enable = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_prime_run();
    test_underrun();
    test_overrun();
    test_watchdog();
    test_enable_drop();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
